mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and
// requester index.
package mem_arb_pkg;

  // Fixed three-phase access sequence.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Index of a requester: 0 = instruction fetch, 1 = load/store.
  typedef logic req_idx_t;

  localparam req_idx_t REQ_FETCH = 1'b0;
  localparam req_idx_t REQ_LS    = 1'b1;

  // Pointer value after reset: requester 1 counts as last granted so that
  // requester 0 wins the first tie.
  localparam req_idx_t PTR_RESET = REQ_LS;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. A lone request always wins; on a tie the
// requester that was not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t pointer,
  output logic     grant_valid,
  output req_idx_t grant_idx
);

  // Grant decision, purely combinational.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = (pointer == REQ_FETCH) ? REQ_LS : REQ_FETCH;
    end else if (req1) begin
      grant_idx = REQ_LS;
    end else begin
      grant_idx = REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-ported data
// memory. Each access takes a fixed IDLE -> ACCESS -> RESP sequence; the
// request is latched at the grant edge so the requester may change its
// inputs afterwards without disturbing the access in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  arb_state_t            state;
  arb_state_t            state_next;
  req_idx_t              last_grant;
  req_idx_t              winner;
  req_idx_t              grant_idx;
  logic                  grant_valid;
  logic                  grant_now;
  logic                  we_lat;
  logic [DATA_WIDTH-1:0] addr_lat;
  logic [DATA_WIDTH-1:0] wdata_lat;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  addr_lsb_unused;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .pointer     (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A grant can only be taken while idle; this is the single edge at which
  // the request and the round-robin pointer are captured.
  assign grant_now = (state == IDLE) && grant_valid;

  // Mux the winning requester's command onto one set of wires.
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (grant_idx == REQ_LS) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Byte offset bits do not select anything: accesses are whole words.
  assign addr_lsb_unused = ^sel_addr[1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: only IDLE waits; the other two phases always advance.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = grant_valid ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winning command and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PTR_RESET;
      winner     <= REQ_FETCH;
      we_lat     <= 1'b0;
      addr_lat   <= '0;
      wdata_lat  <= '0;
    end else if (grant_now) begin
      last_grant <= grant_idx;
      winner     <= grant_idx;
      we_lat     <= sel_we;
      addr_lat   <= {sel_addr[DATA_WIDTH-1:2], 2'b00};
      wdata_lat  <= sel_wdata;
    end
  end

  // Read data lands in the winner's register as ACCESS ends; the other
  // register, and both on a write, keep their previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if ((state == ACCESS) && !we_lat) begin
      if (winner == REQ_FETCH) begin
        rdata0 <= mem_rdata;
      end else begin
        rdata1 <= mem_rdata;
      end
    end
  end

  // Outputs decoded from state so reset clears them immediately, which
  // cuts a write short the moment reset arrives mid-access.
  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      ACCESS: begin
        busy      = 1'b1;
        mem_we    = we_lat;
        mem_addr  = addr_lat;
        mem_wdata = wdata_lat;
      end
      RESP: begin
        busy      = 1'b1;
        mem_addr  = addr_lat;
        mem_wdata = wdata_lat;
        ack0      = (winner == REQ_FETCH);
        ack1      = (winner == REQ_LS);
      end
      default: ;
    endcase
  end

endmodule
